// File: rtl/controller_ws_pkg.sv
// Shared types, encodings and strobe decode for the VeriRISC wait-state sequencer.
package controller_ws_pkg;

    typedef logic [2:0] state_t;
    typedef logic [2:0] opcode_t;

    localparam state_t INST_ADDR  = 3'd0;
    localparam state_t INST_FETCH = 3'd1;
    localparam state_t INST_LOAD  = 3'd2;
    localparam state_t IDLE       = 3'd3;
    localparam state_t OP_ADDR    = 3'd4;
    localparam state_t OP_FETCH   = 3'd5;
    localparam state_t ALU_OP     = 3'd6;
    localparam state_t STORE      = 3'd7;

    localparam opcode_t HLT = 3'd0;
    localparam opcode_t SKZ = 3'd1;
    localparam opcode_t ADD = 3'd2;
    localparam opcode_t AND = 3'd3;
    localparam opcode_t XOR = 3'd4;
    localparam opcode_t LDA = 3'd5;
    localparam opcode_t STO = 3'd6;
    localparam opcode_t JMP = 3'd7;

    localparam int unsigned CTRL_MAX_TIMEOUT = 255;

    typedef struct packed {
        logic mem_rd;
        logic load_ir;
        logic halt;
        logic inc_pc;
        logic load_ac;
        logic load_pc;
        logic mem_wr;
    } strobes_t;

    function automatic strobes_t decode_strobes(input state_t st, input opcode_t op, input logic zero);
        strobes_t s;
        logic     aluop;
        s     = '0;
        aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        case (st)
            INST_ADDR:  s = '0;
            INST_FETCH: s.mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                s.mem_rd  = 1'b1;
                s.load_ir = 1'b1;
            end
            OP_ADDR: begin
                s.inc_pc = 1'b1;
                s.halt   = (op == HLT);
            end
            OP_FETCH:   s.mem_rd = aluop;
            ALU_OP: begin
                s.load_ac = aluop;
                s.mem_rd  = aluop;
                s.inc_pc  = (op == SKZ) && zero;
                s.load_pc = (op == JMP);
            end
            STORE: begin
                s.load_ac = aluop;
                s.mem_rd  = aluop;
                s.inc_pc  = (op == JMP);
                s.load_pc = (op == JMP);
                s.mem_wr  = (op == STO);
            end
            default:    s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controller_ws_wait_timer.sv
// Consecutive memory-stall counter; hit flags the stall cycle that reaches MEM_TIMEOUT.
module ctrl_wait_timer
    import controller_ws_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [7:0] HIT_AT  = 8'(MEM_TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX = 8'(CTRL_MAX_TIMEOUT);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear wins, saturate instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = inc && (count_q == HIT_AT);

endmodule

// File: rtl/controller_ws.sv
// VeriRISC 8-phase sequencer with memory wait states, bus timeout, sticky halt and single-step.
module controller_ws
    import controller_ws_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          STEP_EN     = 1'b1
) (
    input  logic    clk,
    input  logic    rst_,
    input  logic    zero,
    input  opcode_t opcode,
    input  logic    mem_ready,
    input  logic    run,
    input  logic    resume,
    input  logic    step_mode,
    input  logic    step,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr,
    output logic    bus_err,
    output logic    instr_done,
    output state_t  state_o
);

    state_t   state_q, state_d;
    logic     halted_q, halted_d;
    logic     bus_err_q, bus_err_d;
    logic     step_seen_q, step_seen_d;
    strobes_t raw_s, out_s;
    logic     mem_phase, park, advance, halt_set;
    logic     timer_inc, timer_clr, timer_hit;

    ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk  (clk),
        .rst_ (rst_),
        .inc  (timer_inc),
        .clr  (timer_clr),
        .hit  (timer_hit)
    );

    // Strobe decode, advance qualification and next-state for all flags.
    always_comb begin
        raw_s     = decode_strobes(state_q, opcode, zero);
        mem_phase = raw_s.mem_rd | raw_s.mem_wr;
        if (STEP_EN) begin
            park = step_mode & (state_q == INST_ADDR) & ~step_seen_q;
        end else begin
            park = 1'b0;
        end
        // A resume pulse lets the parked OP_FETCH move on at the same edge.
        advance   = run & ~(halted_q & ~resume) & ~bus_err_q & (~mem_phase | mem_ready) & ~park;
        halt_set  = advance & (state_q == OP_ADDR) & (opcode == HLT);
        timer_inc = mem_phase & ~mem_ready & run;
        timer_clr = advance | ~mem_phase;
        state_d   = advance ? state_q + 3'd1 : state_q;
        halted_d  = halt_set ? 1'b1 : (resume ? 1'b0 : halted_q);
        bus_err_d = bus_err_q | timer_hit;
        if (STEP_EN) begin
            step_seen_d = ((state_q == INST_ADDR) && advance) ? 1'b0 : (step ? 1'b1 : step_seen_q);
        end else begin
            step_seen_d = 1'b0;
        end
        out_s = raw_s;
        if (bus_err_q) begin
            out_s = '0;
        end else if (halted_q) begin
            out_s      = '0;
            out_s.halt = 1'b1;
        end else begin
            out_s = raw_s;
        end
        instr_done = (state_q == STORE) & advance;
    end

    // Sequencer state and sticky flags.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= INST_ADDR;
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            step_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            bus_err_q   <= bus_err_d;
            step_seen_q <= step_seen_d;
        end
    end

    assign mem_rd  = out_s.mem_rd;
    assign load_ir = out_s.load_ir;
    assign halt    = out_s.halt;
    assign inc_pc  = out_s.inc_pc;
    assign load_ac = out_s.load_ac;
    assign load_pc = out_s.load_pc;
    assign mem_wr  = out_s.mem_wr;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_controller_ws.sv
// Directed bench for controller_ws: normal loop, wait states, timeout, halt/resume, step, async reset.
module tb_controller_ws;

    logic       clk = 1'b0;
    logic       rst_, zero, mem_ready, run, resume, step_mode, step;
    logic [2:0] opcode;
    logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic       bus_err, instr_done;
    logic [2:0] state_o;
    logic [6:0] strb;
    logic [6:0] exp_add [8];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign strb = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

    controller_ws #(.MEM_TIMEOUT(4), .STEP_EN(1'b1)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .zero       (zero),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .run        (run),
        .resume     (resume),
        .step_mode  (step_mode),
        .step       (step),
        .mem_rd     (mem_rd),
        .load_ir    (load_ir),
        .halt       (halt),
        .inc_pc     (inc_pc),
        .load_ac    (load_ac),
        .load_pc    (load_pc),
        .mem_wr     (mem_wr),
        .bus_err    (bus_err),
        .instr_done (instr_done),
        .state_o    (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} for opcode ADD
        exp_add[0] = 7'b0000000;
        exp_add[1] = 7'b1000000;
        exp_add[2] = 7'b1100000;
        exp_add[3] = 7'b1100000;
        exp_add[4] = 7'b0001000;
        exp_add[5] = 7'b1000000;
        exp_add[6] = 7'b1000100;
        exp_add[7] = 7'b1000100;

        rst_ = 1'b0; zero = 1'b0; mem_ready = 1'b1; run = 1'b1;
        resume = 1'b0; step_mode = 1'b0; step = 1'b0; opcode = 3'd2;
        @(negedge clk);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", 32'(strb), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_done", 32'(instr_done), 32'd0);
        rst_ = 1'b1;

        // Free-running ADD loop, two full instructions
        for (int i = 0; i < 16; i++) begin
            chk("loop_state", 32'(state_o), 32'(i % 8));
            chk("loop_strobes", 32'(strb), 32'(exp_add[i % 8]));
            chk("loop_done", 32'(instr_done), ((i % 8) == 7) ? 32'd1 : 32'd0);
            tick(1);
        end

        // Three wait states in INST_FETCH, ready arrives on the 4th (timeout boundary)
        tick(1);
        chk("ws_enter", 32'(state_o), 32'd1);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("ws_hold", 32'(state_o), 32'd1);
            chk("ws_mem_rd", 32'(mem_rd), 32'd1);
            chk("ws_bus_err", 32'(bus_err), 32'd0);
        end
        mem_ready = 1'b1;
        tick(1);
        chk("ws_release", 32'(state_o), 32'd2);
        chk("ws_no_err", 32'(bus_err), 32'd0);
        tick(6);
        chk("ws_wrap", 32'(state_o), 32'd0);

        // Halt and resume
        opcode = 3'd0;
        tick(4);
        chk("hlt_op_addr", 32'(state_o), 32'd4);
        chk("hlt_op_addr_strb", 32'(strb), 32'(7'b0011000));
        tick(1);
        chk("hlt_state", 32'(state_o), 32'd5);
        chk("hlt_strb", 32'(strb), 32'(7'b0010000));
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("hlt_frozen", 32'(state_o), 32'd5);
        end
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        chk("resume_state", 32'(state_o), 32'd6);
        chk("resume_halt", 32'(halt), 32'd0);
        tick(2);
        chk("resume_wrap", 32'(state_o), 32'd0);

        // Bus timeout in OP_FETCH with LDA (MEM_TIMEOUT = 4)
        opcode = 3'd5;
        tick(5);
        chk("to_state", 32'(state_o), 32'd5);
        chk("to_strb", 32'(strb), 32'(7'b1000000));
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("to_pre_err", 32'(bus_err), 32'd0);
            chk("to_pre_strb", 32'(strb), 32'(7'b1000000));
        end
        tick(1);
        chk("to_err", 32'(bus_err), 32'd1);
        chk("to_err_strb", 32'(strb), 32'd0);
        chk("to_err_state", 32'(state_o), 32'd5);
        mem_ready = 1'b1;
        tick(3);
        chk("to_sticky", 32'(bus_err), 32'd1);
        chk("to_sticky_strb", 32'(strb), 32'd0);
        chk("to_sticky_state", 32'(state_o), 32'd5);
        rst_ = 1'b0;
        #1;
        chk("to_rst_state", 32'(state_o), 32'd0);
        chk("to_rst_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        // Single-step mode
        opcode = 3'd2;
        step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("step_park", 32'(state_o), 32'd0);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        chk("step_pulse", 32'(state_o), 32'd0);
        tick(1);
        chk("step_go", 32'(state_o), 32'd1);
        tick(6);
        chk("step_store", 32'(state_o), 32'd7);
        chk("step_done", 32'(instr_done), 32'd1);
        tick(1);
        chk("step_back", 32'(state_o), 32'd0);
        tick(3);
        chk("step_repark", 32'(state_o), 32'd0);
        chk("step_park_done", 32'(instr_done), 32'd0);
        step_mode = 1'b0;
        tick(1);
        chk("step_off", 32'(state_o), 32'd1);

        // Async reset mid-stall in STORE with STO
        opcode = 3'd6;
        tick(6);
        chk("sto_state", 32'(state_o), 32'd7);
        chk("sto_mem_wr", 32'(mem_wr), 32'd1);
        mem_ready = 1'b0;
        tick(2);
        chk("sto_stall", 32'(state_o), 32'd7);
        chk("sto_stall_wr", 32'(mem_wr), 32'd1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        chk("arst_bus_err", 32'(bus_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
